// File: rtl/mcu_cmd_if.sv
// Memory-bus handshake between the MCU command decoder (master) and the
// bus synchroniser (slave).
interface mcu_cmd_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  pending;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data_out;
    logic                  rw_b;
    logic                  done;
    logic [7:0]            bus_data_in;

    modport master (
        output pending, addr, data_out, rw_b,
        input  done, bus_data_in
    );

    modport slave (
        input  pending, addr, data_out, rw_b,
        output done, bus_data_in
    );
endinterface

// File: rtl/mcu_cmd.sv
// Assembles SPI bytes into single memory-bus transactions and holds each one
// on the bus until the synchroniser reports completion.
module mcu_cmd #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             frame_reset,
    mcu_cmd_if.master        bus,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, ARG, PENDING} state_e;
    typedef enum logic [1:0] {OP_WRITE_AT, OP_READ_AT, OP_WRITE_NEXT, OP_READ_NEXT} op_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  a16_q, a16_d;
    logic [7:0]            data_stage_q, data_stage_d;
    logic [7:0]            hi_stage_q, hi_stage_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_out_q, data_out_d;
    logic                  rw_b_q, rw_b_d;
    logic                  pending_q, pending_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;

    logic                  byte_ok;

    // A byte coinciding with frame_reset is always dropped.
    assign byte_ok = rx_valid && !frame_reset;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        a16_d        = a16_q;
        data_stage_d = data_stage_q;
        hi_stage_d   = hi_stage_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        rw_b_d       = rw_b_q;
        pending_d    = pending_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (byte_ok && !rx_data[7]) begin
                    op_d  = op_e'(rx_data[6:5]);
                    a16_d = rx_data[0];
                    case (op_e'(rx_data[6:5]))
                        OP_WRITE_AT: begin
                            cnt_d   = 2'd3;
                            state_d = ARG;
                        end
                        OP_READ_AT: begin
                            cnt_d   = 2'd2;
                            state_d = ARG;
                        end
                        OP_WRITE_NEXT: begin
                            cnt_d   = 2'd1;
                            state_d = ARG;
                        end
                        default: begin
                            rw_b_d    = 1'b1;
                            pending_d = 1'b1;
                            state_d   = PENDING;
                        end
                    endcase
                end
            end

            ARG: begin
                if (frame_reset) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        // Argument bytes are staged so an aborted frame never
                        // disturbs the committed transaction fields.
                        case (op_q)
                            OP_WRITE_AT: begin
                                addr_d     = ADDR_WIDTH'({a16_q, hi_stage_q, rx_data});
                                data_out_d = data_stage_q;
                                rw_b_d     = 1'b0;
                            end
                            OP_READ_AT: begin
                                addr_d = ADDR_WIDTH'({a16_q, hi_stage_q, rx_data});
                                rw_b_d = 1'b1;
                            end
                            default: begin
                                data_out_d = rx_data;
                                rw_b_d     = 1'b0;
                            end
                        endcase
                        pending_d = 1'b1;
                        state_d   = PENDING;
                    end else if (cnt_q == 2'd3) begin
                        data_stage_d = rx_data;
                    end else begin
                        hi_stage_d = rx_data;
                    end
                end
            end

            PENDING: begin
                if (byte_ok) begin
                    overrun_d = 1'b1;
                end
                if (bus.done) begin
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    pending_d = 1'b0;
                    state_d   = IDLE;
                    if (rw_b_q) begin
                        rd_data_d  = bus.bus_data_in;
                        rd_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_WRITE_AT;
            cnt_q        <= '0;
            a16_q        <= 1'b0;
            data_stage_q <= '0;
            hi_stage_q   <= '0;
            addr_q       <= '0;
            data_out_q   <= '0;
            rw_b_q       <= 1'b1;
            pending_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            a16_q        <= a16_d;
            data_stage_q <= data_stage_d;
            hi_stage_q   <= hi_stage_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            rw_b_q       <= rw_b_d;
            pending_q    <= pending_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.pending  = pending_q;
    assign bus.addr     = addr_q;
    assign bus.data_out = data_out_q;
    assign bus.rw_b     = rw_b_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_mcu_cmd.sv
// Directed and randomized checks of mcu_cmd against a byte-queue reference
// model of the command protocol.
module tb_mcu_cmd;
    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_reset;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overrun;

    mcu_cmd_if #(.ADDR_WIDTH(17)) bus ();

    mcu_cmd #(.ADDR_WIDTH(17)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_reset (frame_reset),
        .bus         (bus),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: collected command bytes plus committed bus fields.
    logic [7:0]  m_q[$];
    bit          m_busy;
    int unsigned m_addr;
    logic [7:0]  m_data;
    bit          m_rw;
    logic [7:0]  m_rd;
    bit          m_rdv;
    bit          m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_addr = 0;
        m_data = 8'h00;
        m_rw   = 1;
        m_rd   = 8'h00;
        m_rdv  = 0;
        m_ovr  = 0;
    endtask

    function automatic int unsigned cmd_len(input logic [7:0] op);
        case (op[6:5])
            2'd0:    return 4;
            2'd1:    return 3;
            2'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_edge(input bit rxv, input logic [7:0] rxd, input bit fr,
                              input bit dn, input logic [7:0] bdi);
        m_rdv = 0;
        if (m_busy) begin
            if (rxv && !fr) m_ovr = 1;
            if (dn) begin
                m_busy = 0;
                m_addr = (m_addr + 1) % 32'h20000;
                if (m_rw) begin
                    m_rd  = bdi;
                    m_rdv = 1;
                end
            end
        end else if (fr) begin
            m_q.delete();
        end else if (rxv && !(m_q.size() == 0 && rxd[7])) begin
            m_q.push_back(rxd);
            if (m_q.size() == cmd_len(m_q[0])) begin
                case (m_q[0][6:5])
                    2'd0: begin
                        m_addr = {15'd0, m_q[0][0], m_q[2], m_q[3]};
                        m_data = m_q[1];
                        m_rw   = 0;
                    end
                    2'd1: begin
                        m_addr = {15'd0, m_q[0][0], m_q[1], m_q[2]};
                        m_rw   = 1;
                    end
                    2'd2: begin
                        m_data = m_q[1];
                        m_rw   = 0;
                    end
                    default: m_rw = 1;
                endcase
                m_busy = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("pending",  32'(bus.pending),  32'(m_busy));
        check("addr",     32'(bus.addr),     m_addr);
        check("data_out", 32'(bus.data_out), 32'(m_data));
        check("rw_b",     32'(bus.rw_b),     32'(m_rw));
        check("rd_data",  32'(rd_data),      32'(m_rd));
        check("rd_valid", 32'(rd_valid),     32'(m_rdv));
        check("overrun",  32'(overrun),      32'(m_ovr));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic step(input bit rxv, input logic [7:0] rxd, input bit fr,
                        input bit dn, input logic [7:0] bdi);
        rx_valid        = rxv;
        rx_data         = rxd;
        frame_reset     = fr;
        bus.done        = dn;
        bus.bus_data_in = bdi;
        @(posedge clk);
        model_edge(rxv, rxd, fr, dn, bdi);
        #1;
        compare_all();
        rx_valid    = 1'b0;
        frame_reset = 1'b0;
        bus.done    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0, 0, 8'h00);
    endtask

    task automatic finish_access(input logic [7:0] bdi);
        step(0, 8'h00, 0, 0, 8'h00);
        step(0, 8'h00, 0, 1, bdi);
    endtask

    initial begin
        reset           = 1'b1;
        rx_data         = 8'h00;
        rx_valid        = 1'b0;
        frame_reset     = 1'b0;
        bus.done        = 1'b0;
        bus.bus_data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Write 0x55 to 0x18000
        send(8'h01); send(8'h55); send(8'h80);
        check("wr_not_yet_pending", 32'(bus.pending), 32'd0);
        send(8'h00);
        check("wr_pending", 32'(bus.pending), 32'd1);
        check("wr_addr", 32'(bus.addr), 32'h18000);
        check("wr_data", 32'(bus.data_out), 32'h55);
        check("wr_rw_b", 32'(bus.rw_b), 32'd0);
        finish_access(8'hEE);
        check("wr_done_pending", 32'(bus.pending), 32'd0);
        check("wr_done_addr", 32'(bus.addr), 32'h18001);
        check("wr_no_rd_valid", 32'(rd_valid), 32'd0);

        // Read 0x0FFFF returning 0xA5
        send(8'h20); send(8'hFF); send(8'hFF);
        check("rd_addr", 32'(bus.addr), 32'h0FFFF);
        check("rd_rw_b", 32'(bus.rw_b), 32'd1);
        finish_access(8'hA5);
        check("rd_data", 32'(rd_data), 32'hA5);
        check("rd_valid_hi", 32'(rd_valid), 32'd1);
        check("rd_next_addr", 32'(bus.addr), 32'h10000);
        step(0, 8'h00, 0, 0, 8'h00);
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);

        // Wrap at top of address space
        send(8'h21); send(8'hFF); send(8'hFF);
        check("wrap_addr_top", 32'(bus.addr), 32'h1FFFF);
        finish_access(8'h11);
        send(8'h60);
        check("wrap_addr_zero", 32'(bus.addr), 32'h00000);
        check("wrap_pending", 32'(bus.pending), 32'd1);
        finish_access(8'h22);
        check("wrap_after", 32'(bus.addr), 32'h00001);

        // Abort partial WRITE_AT, then a byte dropped by simultaneous frame_reset
        send(8'h00); send(8'h99);
        step(0, 8'h00, 1, 0, 8'h00);
        check("abort_no_pending", 32'(bus.pending), 32'd0);
        step(1, 8'h60, 1, 0, 8'h00);
        check("drop_no_pending", 32'(bus.pending), 32'd0);
        send(8'h60);
        check("abort_rn_addr", 32'(bus.addr), 32'h00001);
        finish_access(8'h33);

        // Overrun during pending
        send(8'h40); send(8'h3C);
        send(8'h77);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_addr", 32'(bus.addr), 32'h00002);
        check("ovr_data", 32'(bus.data_out), 32'h3C);
        finish_access(8'h00);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-access
        send(8'h40); send(8'h44);
        check("rst_pre_pending", 32'(bus.pending), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_pending", 32'(bus.pending), 32'd0);
        compare_all();
        @(posedge clk);
        #1 reset = 1'b0;
        send(8'h40); send(8'h99);
        check("rst_wn_addr", 32'(bus.addr), 32'h00000);
        check("rst_wn_data", 32'(bus.data_out), 32'h99);
        finish_access(8'h00);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit         rxv, fr, dn;
            logic [7:0] rxd;
            rxv = ($urandom_range(0, 1) == 1);
            rxd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) rxd[7] = 1'b0;
            fr  = ($urandom_range(0, 15) == 0);
            if (m_busy && rxv) fr = 0;
            dn  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            step(rxv, rxd, fr, dn, 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
